bound_flasher_gen: RTL

//  Parametrised bound flasher: drives a bar of N_LAMPS lamps as a fill level L (lamp[i]=1 iff i<L).
//  One flick runs three fill/drain passes with bounds B1, B2 and N_LAMPS, then returns to idle.

---
 rtl/bound_flasher_gen.sv | 118 +++++++++++
 1 files changed

// File: rtl/bound_flasher_gen.sv
// Bound flasher: runs a thermometer-coded lamp bar through three fill/drain passes per flick.
// Kickbacks at the inner bounds re-run a pass. A prescaler paces the steps, and hold freezes the sequence.
module bound_flasher_gen #(
    parameter int N_LAMPS  = 16,
    parameter int B1       = 6,
    parameter int B2       = 11,
    parameter int STEP_DIV = 1,
    localparam int LW      = $clog2(N_LAMPS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flick,
    input  logic               hold,
    output logic [N_LAMPS-1:0] lamp,
    output logic [LW-1:0]      level,
    output logic               busy,
    output logic               done
);

    if (N_LAMPS < 3 || B1 < 1 || B1 >= B2 || B2 >= N_LAMPS || STEP_DIV < 1) begin : g_bad_params
        $error("bound_flasher_gen: illegal N_LAMPS/B1/B2/STEP_DIV combination");
    end

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [LW-1:0] LV_B1   = LW'(B1);
    localparam logic [LW-1:0] LV_B2   = LW'(B2);
    localparam logic [LW-1:0] LV_MAX  = LW'(N_LAMPS);
    localparam logic [PW-1:0] PS_LAST = PW'(STEP_DIV - 1);

    typedef enum logic [2:0] {IDLE, UP1, DN1, UP2, DN2, UP3, DN3, DNK} state_t;

    state_t               state_q, state_d;
    logic [LW-1:0]        level_q, level_d, lvl_new;
    logic [PW-1:0]        presc_q, presc_d;
    logic [N_LAMPS-1:0]   lamp_q, lamp_d;
    logic                 done_q, done_d;
    logic                 step, is_up;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        lvl_new = level_q;
        is_up   = (state_q == UP1) || (state_q == UP2) || (state_q == UP3);
        step    = !hold && (state_q != IDLE) && (presc_q == PS_LAST);

        if (!hold) begin
            if (state_q == IDLE) begin
                if (flick) begin
                    state_d = UP1;
                    level_d = LW'(1);
                    presc_d = '0;
                end
            end else if (presc_q == PS_LAST) begin
                presc_d = '0;
                lvl_new = is_up ? level_q + LW'(1) : level_q - LW'(1);
                level_d = lvl_new;
                // Transitions look at the level this edge produces, not the old one.
                case (state_q)
                    UP1: if (lvl_new == LV_B1) state_d = DN1;
                    DN1: if (lvl_new == '0) state_d = UP2;
                    UP2: begin
                        if (flick && (lvl_new == LV_B1 || lvl_new == LV_B2)) state_d = DNK;
                        else if (lvl_new == LV_B2)                           state_d = DN2;
                    end
                    DN2: if (lvl_new == LV_B1) state_d = UP3;
                    UP3: begin
                        if (flick && lvl_new == LV_B2) state_d = DN2;
                        else if (lvl_new == LV_MAX)    state_d = DN3;
                    end
                    DN3: begin
                        if (lvl_new == '0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                    DNK: if (lvl_new == '0) state_d = UP2;
                    default: state_d = IDLE;
                endcase
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        for (int i = 0; i < N_LAMPS; i++) begin
            lamp_d[i] = (level_d > LW'(i));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            level_q <= '0;
            presc_q <= '0;
            lamp_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            presc_q <= presc_d;
            lamp_q  <= lamp_d;
            done_q  <= done_d;
        end
    end

    assign lamp  = lamp_q;
    assign level = level_q;
    assign busy  = (state_q != IDLE);
    assign done  = done_q;

    a_level_max: assert property (@(posedge clk) disable iff (!rst_n) level_q <= LV_MAX);
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) (step && !is_up) |-> (level_q != '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) (step && is_up) |-> (level_q != LV_MAX));

endmodule
